// File: rtl/cmd_pkg.sv
// Shared types and constants for the command receive path.
// Optional feature macro: CMD_RECEIVE_CHECKSUM_EN (adds the CHK framer state).
package cmd_pkg;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_packet_t;

  localparam logic [7:0] CMD_SOF      = 8'hA5;
  localparam logic [7:0] CMD_OP_WRITE = 8'h01;
  localparam logic [7:0] CMD_OP_READ  = 8'h02;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    FR_HUNT,
    FR_OPC,
    FR_ADDR,
    FR_DATA,
`ifdef CMD_RECEIVE_CHECKSUM_EN
    FR_CHK,
`endif
    FR_PUSH
  } frm_state_t;

  function automatic logic is_valid_opcode(input logic [7:0] op);
    return (op == CMD_OP_WRITE) || (op == CMD_OP_READ);
  endfunction

endpackage

// File: rtl/cmd_receive_uart_rx.sv
// UART byte receiver: 2-flop synchronizer, start-bit glitch rejection,
// mid-bit sampling at OVERSAMPLE ticks per bit, LSB first, stop-bit check.
// Optional feature macro: CMD_RECEIVE_CHECKSUM_EN (not used in this file).
module uart_rx
  import cmd_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       os_tick,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_err
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] FULL_LAST = OS_W'(OVERSAMPLE - 1);

  logic            r_rx_meta;
  logic            r_rx_sync;
  logic            r_rx_prev;
  rx_state_t       r_state;
  rx_state_t       w_state_nxt;
  logic [OS_W-1:0] r_os_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_byte_valid;
  logic            r_stop_err;
  logic            w_fall;
  logic            w_half_hit;
  logic            w_full_hit;
  logic            w_valid_nxt;
  logic            w_err_nxt;

  assign w_fall     = r_rx_prev & ~r_rx_sync;
  assign w_half_hit = os_tick && (r_os_cnt == HALF_LAST);
  assign w_full_hit = os_tick && (r_os_cnt == FULL_LAST);

  // Synchronize rx and keep the previous synchronized value for edge detection.
  // NOTE: the chain resets to 0 rather than the idle level so that a line
  // held low through reset release never looks like a start edge; the line
  // has to be seen high first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b0;
      r_rx_sync <= 1'b0;
      r_rx_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here make every flop sample the
      // pre-edge value of its source, which is what builds a real shift chain.
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Byte receiver state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RX_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Byte receiver next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_state_nxt = RX_START;
      RX_START: if (w_half_hit) w_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full_hit && (r_bit_cnt == 3'd7)) w_state_nxt = RX_STOP;
      RX_STOP:  if (w_full_hit) w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  // Byte receiver outputs: decide the stop-bit result on the sampling tick.
  always_comb begin
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    if ((r_state == RX_STOP) && w_full_hit) begin
      w_valid_nxt = r_rx_sync;
      w_err_nxt   = ~r_rx_sync;
    end
  end

  // Tick/bit counters, shift register and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_os_cnt     <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_byte_valid <= w_valid_nxt;
      r_stop_err   <= w_err_nxt;
      case (r_state)
        RX_START: begin
          if (w_half_hit)   r_os_cnt <= '0;
          else if (os_tick) r_os_cnt <= r_os_cnt + OS_W'(1);
        end
        RX_DATA, RX_STOP: begin
          if (w_full_hit)   r_os_cnt <= '0;
          else if (os_tick) r_os_cnt <= r_os_cnt + OS_W'(1);
          if (w_full_hit && (r_state == RX_DATA)) begin
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        default: begin
          r_os_cnt  <= '0;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign byte_data  = r_shift;
  assign byte_valid = r_byte_valid;
  assign stop_err   = r_stop_err;

endmodule

// File: rtl/cmd_receive.sv
// Command receive front end: frames UART bytes (SOF, opcode, addr, data)
// into cmd_packet_t words for the command FIFO, with an inter-byte timeout,
// error/overflow pulses and a saturating drop counter.
// Optional feature macro: CMD_RECEIVE_CHECKSUM_EN adds a trailing XOR
// checksum byte checked in the CHK state.
module cmd_receive
  import cmd_pkg::*;
#(
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        os_tick,
  input  logic        rx,
  input  logic        cmd_fifo_full,
  output logic        cmd_fifo_wr_en,
  output cmd_packet_t cmd_fifo_wr_data,
  output logic        frame_err,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int TO_W = (TIMEOUT_BITS > 1) ? $clog2(TIMEOUT_BITS) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_BITS - 1);

  logic [7:0]      w_byte_data;
  logic            w_byte_valid;
  logic            w_stop_err;
  frm_state_t      r_frm;
  frm_state_t      w_frm_nxt;
  logic [7:0]      r_opcode;
  logic [7:0]      r_addr;
`ifdef CMD_RECEIVE_CHECKSUM_EN
  logic [7:0]      r_data;
`endif
  cmd_packet_t     r_pkt;
  logic [OS_W-1:0] r_to_os;
  logic [TO_W-1:0] r_to_bits;
  logic [7:0]      r_drop_cnt;
  logic            w_in_frame;
  logic            w_timeout;
  logic            w_opc_bad;
  logic            w_chk_bad;
  logic            w_frame_abort;
  logic            w_drop;

  uart_rx #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_uart_rx (
    .clk       (clk),
    .rst       (rst),
    .os_tick   (os_tick),
    .rx        (rx),
    .byte_data (w_byte_data),
    .byte_valid(w_byte_valid),
    .stop_err  (w_stop_err)
  );

  // A frame is "in progress" between SOF and the push decision.
  assign w_in_frame    = (r_frm != FR_HUNT) && (r_frm != FR_PUSH);
  // A byte arriving on the last tick wins over the timeout.
  assign w_timeout     = w_in_frame && !w_byte_valid && os_tick &&
                         (r_to_os == OS_LAST) && (r_to_bits == TO_LAST);
  assign w_opc_bad     = (r_frm == FR_OPC) && w_byte_valid && !is_valid_opcode(w_byte_data);
  assign w_frame_abort = w_in_frame && w_stop_err;
`ifdef CMD_RECEIVE_CHECKSUM_EN
  assign w_chk_bad     = (r_frm == FR_CHK) && w_byte_valid &&
                         (w_byte_data != (r_opcode ^ r_addr ^ r_data));
`else
  assign w_chk_bad     = 1'b0;
`endif

  // Framer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_frm <= FR_HUNT;
    else      r_frm <= w_frm_nxt;
  end

  // Framer next-state logic; any abort cause overrides back to HUNT.
  always_comb begin
    w_frm_nxt = r_frm;
    case (r_frm)
      FR_HUNT: if (w_byte_valid && (w_byte_data == CMD_SOF)) w_frm_nxt = FR_OPC;
      FR_OPC:  if (w_byte_valid) w_frm_nxt = is_valid_opcode(w_byte_data) ? FR_ADDR : FR_HUNT;
      FR_ADDR: if (w_byte_valid) w_frm_nxt = FR_DATA;
`ifdef CMD_RECEIVE_CHECKSUM_EN
      FR_DATA: if (w_byte_valid) w_frm_nxt = FR_CHK;
      FR_CHK:  if (w_byte_valid) w_frm_nxt = w_chk_bad ? FR_HUNT : FR_PUSH;
`else
      FR_DATA: if (w_byte_valid) w_frm_nxt = FR_PUSH;
`endif
      FR_PUSH: w_frm_nxt = FR_HUNT;
      default: w_frm_nxt = FR_HUNT;
    endcase
    if (w_frame_abort || w_timeout) w_frm_nxt = FR_HUNT;
  end

  // Framer outputs: write/overflow decided in PUSH, error pulses from all causes.
  always_comb begin
    cmd_fifo_wr_en = (r_frm == FR_PUSH) && !cmd_fifo_full;
    overflow       = (r_frm == FR_PUSH) && cmd_fifo_full;
    frame_err      = w_stop_err || w_opc_bad || w_chk_bad || w_timeout;
    w_drop         = w_opc_bad || w_chk_bad || w_timeout || w_frame_abort ||
                     ((r_frm == FR_PUSH) && cmd_fifo_full);
  end

  // Capture frame fields; the output word only changes when a complete,
  // checked frame is about to be pushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opcode <= '0;
      r_addr   <= '0;
`ifdef CMD_RECEIVE_CHECKSUM_EN
      r_data   <= '0;
`endif
      r_pkt    <= '0;
    end else if (w_byte_valid) begin
      if (r_frm == FR_OPC)  r_opcode <= w_byte_data;
      if (r_frm == FR_ADDR) r_addr   <= w_byte_data;
`ifdef CMD_RECEIVE_CHECKSUM_EN
      if (r_frm == FR_DATA) r_data   <= w_byte_data;
      if ((r_frm == FR_CHK) && !w_chk_bad)
        r_pkt <= '{opcode: r_opcode, addr: r_addr, data: r_data};
`else
      if (r_frm == FR_DATA)
        r_pkt <= '{opcode: r_opcode, addr: r_addr, data: w_byte_data};
`endif
    end
  end

  // Inter-byte timeout: bit periods elapsed since the last byte of a live frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_os   <= '0;
      r_to_bits <= '0;
    end else if (w_byte_valid || !w_in_frame || w_timeout) begin
      r_to_os   <= '0;
      r_to_bits <= '0;
    end else if (os_tick) begin
      if (r_to_os == OS_LAST) begin
        r_to_os   <= '0;
        r_to_bits <= r_to_bits + TO_W'(1);
      end else begin
        r_to_os <= r_to_os + OS_W'(1);
      end
    end
  end

  // Saturating count of dropped frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign cmd_fifo_wr_data = r_pkt;
  assign drop_cnt         = r_drop_cnt;

endmodule

// File: tb/tb_cmd_receive.sv
// Testbench for cmd_receive: serial stimulus with a byte-list reference
// model feeding an expected-event scoreboard, checked by a monitor.
// Optional feature macro: CMD_RECEIVE_CHECKSUM_EN (bench follows the build).
`timescale 1ns/1ps
module tb_cmd_receive;
  import cmd_pkg::*;

  localparam int OS       = 16;
  localparam int TO       = 32;
  localparam int TICK_DIV = 2;
  localparam int K_WRITE  = 1;
  localparam int K_ERR    = 2;
  localparam int K_OVF    = 3;
`ifdef CMD_RECEIVE_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        os_tick = 1'b0;
  logic        rx = 1'b1;
  logic        cmd_fifo_full = 1'b0;
  logic        cmd_fifo_wr_en;
  cmd_packet_t cmd_fifo_wr_data;
  logic        frame_err;
  logic        overflow;
  logic [7:0]  drop_cnt;

  cmd_receive #(
    .OVERSAMPLE  (OS),
    .TIMEOUT_BITS(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .os_tick         (os_tick),
    .rx              (rx),
    .cmd_fifo_full   (cmd_fifo_full),
    .cmd_fifo_wr_en  (cmd_fifo_wr_en),
    .cmd_fifo_wr_data(cmd_fifo_wr_data),
    .frame_err       (frame_err),
    .overflow        (overflow),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  // Oversample tick: one clk wide, changed on the falling edge.
  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      os_tick = 1'b1;
      @(negedge clk);
      os_tick = 1'b0;
    end
  end

  typedef struct {
    int         kind;
    logic [23:0] data;
  } want_t;

  want_t      want_q[$];
  logic [7:0] frm_q[$];
  int         model_drop = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_want(input int kind, input logic [23:0] data);
    want_t w;
    w.kind = kind;
    w.data = data;
    want_q.push_back(w);
  endtask

  task automatic model_drop_frame();
    if (model_drop < 255) model_drop++;
    frm_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      push_want(K_ERR, '0);
      if (frm_q.size() > 0) model_drop_frame();
      return;
    end
    if (frm_q.size() == 0) begin
      if (b == CMD_SOF) frm_q.push_back(b);
      return;
    end
    if (frm_q.size() == 1 && b != CMD_OP_WRITE && b != CMD_OP_READ) begin
      push_want(K_ERR, '0);
      model_drop_frame();
      return;
    end
    frm_q.push_back(b);
    if (frm_q.size() == FRAME_LEN) begin
`ifdef CMD_RECEIVE_CHECKSUM_EN
      if (frm_q[4] != (frm_q[1] ^ frm_q[2] ^ frm_q[3])) begin
        push_want(K_ERR, '0);
        model_drop_frame();
        return;
      end
`endif
      if (cmd_fifo_full) begin
        push_want(K_OVF, '0);
        model_drop_frame();
      end else begin
        push_want(K_WRITE, {frm_q[1], frm_q[2], frm_q[3]});
        frm_q.delete();
      end
    end
  endtask

  task automatic model_idle(input int bits);
    if (frm_q.size() > 0 && bits >= TO) begin
      push_want(K_ERR, '0);
      model_drop_frame();
    end
  endtask

  // ---------------- monitor ----------------
  task automatic match_event(input int kind, input logic [23:0] data);
    want_t w;
    if (want_q.size() == 0) begin
      check("unexpected_event", kind, 0);
      return;
    end
    w = want_q.pop_front();
    check("event_kind", kind, w.kind);
    if (kind == K_WRITE && w.kind == K_WRITE) check("wr_data", data, w.data);
  endtask

  always @(negedge clk) begin
    if (rst && (cmd_fifo_wr_en || frame_err || overflow)) begin
      check("err_ovf_exclusive", {31'b0, frame_err & overflow}, 0);
      if (cmd_fifo_wr_en) match_event(K_WRITE, cmd_fifo_wr_data);
      if (frame_err)      match_event(K_ERR, '0);
      if (overflow)       match_event(K_OVF, '0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
  endtask

  task automatic drive_rx(input logic v);
    @(negedge clk);
    rx = v;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    drive_rx(1'b0);
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      drive_rx(b[i]);
      wait_ticks(OS);
    end
    model_byte(b, stop_ok);
    drive_rx(stop_ok);
    wait_ticks(OS);
    drive_rx(1'b1);
    wait_ticks(OS * gap);
  endtask

  // Sends a complete command; bad_idx selects a byte whose stop bit is forced low.
  task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                          input int bad_idx);
    logic [7:0] f[$];
    f = '{CMD_SOF, op, a, d};
`ifdef CMD_RECEIVE_CHECKSUM_EN
    f.push_back(op ^ a ^ d);
`endif
    for (int i = 0; i < f.size(); i++)
      send_byte(f[i], i != bad_idx, 1 + int'($urandom_range(0, 2)));
  endtask

  task automatic check_drop(input string name);
    check(name, {24'b0, drop_cnt}, model_drop);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},    {31'b0, cmd_fifo_wr_en}, 0);
    check({tag, "_frame_err"}, {31'b0, frame_err}, 0);
    check({tag, "_overflow"}, {31'b0, overflow}, 0);
    check({tag, "_drop_cnt"}, {24'b0, drop_cnt}, 0);
    check({tag, "_wr_data"},  {8'b0, cmd_fifo_wr_data}, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit, %0d pending events", want_q.size());
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int         sel;
    logic [7:0] op;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    wait_ticks(2 * OS);

    // Plain write command.
    send_cmd(8'h01, 8'h3C, 8'h5A, -1);
    check_drop("drop_after_write");

    // Noise ahead of SOF, then a read.
    send_byte(8'h00, 1'b1, 1);
    send_byte(8'hFF, 1'b1, 1);
    send_cmd(8'h02, 8'h10, 8'h00, -1);
    check_drop("drop_after_noise_read");

    // Bad stop bit on the addr byte, then a clean frame.
    send_cmd(8'h01, 8'h44, 8'h55, 2);
    check_drop("drop_after_bad_stop");
    send_cmd(8'h01, 8'h22, 8'h33, -1);
    check_drop("drop_after_recovery");

    // Bad opcode, then a short low glitch that must be ignored.
    send_byte(CMD_SOF, 1'b1, 1);
    send_byte(8'h07, 1'b1, 1);
    drive_rx(1'b0);
    wait_ticks(4);
    drive_rx(1'b1);
    wait_ticks(2 * OS);
    check_drop("drop_after_bad_opc_glitch");

    // Inter-byte timeout.
    send_byte(CMD_SOF, 1'b1, 1);
    send_byte(8'h01, 1'b1, 0);
    model_idle(40);
    wait_ticks(40 * OS);
    check_drop("drop_after_timeout");

    // Complete frame while the FIFO is full.
    @(negedge clk);
    cmd_fifo_full = 1'b1;
    send_cmd(8'h01, 8'h99, 8'hAB, -1);
    @(negedge clk);
    cmd_fifo_full = 1'b0;
    check_drop("drop_after_overflow");

`ifdef CMD_RECEIVE_CHECKSUM_EN
    send_byte(CMD_SOF, 1'b1, 1);
    send_byte(8'h01, 1'b1, 1);
    send_byte(8'h3C, 1'b1, 1);
    send_byte(8'h5A, 1'b1, 1);
    send_byte(8'h67, 1'b1, 1);
    check_drop("drop_after_good_chk");
    send_byte(CMD_SOF, 1'b1, 1);
    send_byte(8'h01, 1'b1, 1);
    send_byte(8'h3C, 1'b1, 1);
    send_byte(8'h5A, 1'b1, 1);
    send_byte(8'h00, 1'b1, 1);
    check_drop("drop_after_bad_chk");
`endif

    // Randomized traffic.
    for (int n = 0; n < 16; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        op = 8'($urandom_range(0, 255));
        if (op == CMD_SOF) op = 8'h5A;
        send_byte(op, 1'b1, 1);
      end else if (sel == 1) begin
        op = 8'($urandom_range(3, 255));
        send_cmd(op, 8'($urandom), 8'($urandom), -1);
      end else if (sel == 2) begin
        send_cmd(8'($urandom_range(1, 2)), 8'($urandom), 8'($urandom),
                 int'($urandom_range(1, FRAME_LEN - 1)));
      end else if (sel == 3) begin
        @(negedge clk);
        cmd_fifo_full = 1'b1;
        send_cmd(8'($urandom_range(1, 2)), 8'($urandom), 8'($urandom), -1);
        @(negedge clk);
        cmd_fifo_full = 1'b0;
      end else begin
        send_cmd(8'($urandom_range(1, 2)), 8'($urandom), 8'($urandom), -1);
      end
      check_drop("drop_random");
    end

    // Reset in the middle of the DATA byte.
    send_byte(CMD_SOF, 1'b1, 1);
    send_byte(8'h01, 1'b1, 1);
    send_byte(8'h3C, 1'b1, 1);
    drive_rx(1'b0);
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      drive_rx(1'(i & 1));
      wait_ticks(OS);
    end
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    frm_q.delete();
    model_drop = 0;
    check("pending_at_reset", want_q.size(), 0);
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b1;
    wait_ticks(2 * OS);
    send_cmd(8'h02, 8'h77, 8'h88, -1);
    check_drop("drop_after_midreset");

    wait_ticks(2 * OS);
    check("scoreboard_empty", want_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
